// File: rtl/tomasulo_pkg.sv
// Shared types for the tomasulo dispatch/rename stage and its neighbours.
// Latency: n/a (types, constants and operand-packing helpers only).
// Backpressure: n/a.
package tomasulo_pkg;

  localparam int WORD_W  = 32;
  localparam int TAG_W   = 3;
  localparam int ROBID_W = 4;
  localparam int IMM_W   = 16;
  localparam int REG_W   = 3;   // wide enough for the largest supported NREG (8)

  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [TAG_W-1:0]   tag_t;
  typedef logic [ROBID_W-1:0] robid_t;
  typedef logic [IMM_W-1:0]   imm_t;
  typedef logic [REG_W-1:0]   reg_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_LD  = 3'd5,
    OP_ST  = 3'd6,
    OP_NOP = 3'd7
  } opcode_t;

  // A waiting operand carries its producer tag in the low bits of the word slot.
  typedef struct packed {
    logic [WORD_W-TAG_W-1:0] pad;
    tag_t                    tag;
  } tagref_t;

  typedef union packed {
    word_t   w;
    tagref_t t;
  } oprand_u_t;

  typedef struct packed {
    logic      busy;
    oprand_u_t u;
  } oprand_t;

  typedef struct packed {
    opcode_t         opcode;
    robid_t          robid;
    tag_t            tag;
    oprand_t [1:0]   oprand;
    imm_t            imm;
  } dispatch_t;

  typedef struct packed {
    logic  vld;
    tag_t  tag;
    word_t wdata;
  } cdb_t;

  typedef struct packed {
    opcode_t      opcode;
    reg_t         dst;
    reg_t [1:0]   src;
    imm_t         imm;
  } inst_t;

  typedef struct packed {
    logic  busy;
    tag_t  tag;
    word_t data;
  } regstat_t;

  function automatic oprand_t mk_val(input word_t w);
    oprand_t o;
    o.busy = 1'b0;
    o.u.w  = w;
    return o;
  endfunction

  function automatic oprand_t mk_tag(input tag_t t);
    oprand_t o;
    o.busy    = 1'b1;
    o.u.t.pad = '0;
    o.u.t.tag = t;
    return o;
  endfunction

endpackage

// File: rtl/tomasulo_dispatch_tag_alloc.sv
// Rename-tag free list: lowest-index allocate, CDB-driven release.
// Latency: allocation is combinational; a released tag becomes visible next cycle.
// Backpressure: avail=0 when every tag is in flight; caller must not alloc then.
// Ports: clk/rst (sync, active-high); alloc consumes alloc_tag; rel/rel_tag return a tag.
module tomasulo_tag_alloc
  import tomasulo_pkg::*;
#(
  parameter int NTAG = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic alloc,
  input  logic rel,
  input  tag_t rel_tag,
  output logic avail,
  output tag_t alloc_tag
);

  logic [NTAG-1:0] free_r;

  // Scan from the top so the last write leaves the lowest free index.
  always_comb begin
    avail     = 1'b0;
    alloc_tag = '0;
    for (int i = NTAG - 1; i >= 0; i--) begin
      if (free_r[i]) begin
        avail     = 1'b1;
        alloc_tag = tag_t'(i);
      end
    end
  end

  // The released tag is in flight, hence never equal to alloc_tag: the two
  // updates touch different bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      free_r <= '1;
    end else begin
      if (alloc) free_r[alloc_tag] <= 1'b0;
      if (rel)   free_r[rel_tag]   <= 1'b1;
    end
  end

endmodule

// File: rtl/tomasulo_dispatch.sv
// Dispatch/rename stage feeding the reservation station; snoops the CDB.
// Latency: 1 cycle from accepted ins to dis_vld_r/dis_r.
// Backpressure: ins_accept drops on rob_full, zero RS credits, empty tag pool or bypass stall.
// Ports: clk/rst (sync, active-high); ins_vld/ins/ins_accept front-end handshake;
//   rob_full; rs_iss_vld_r returns one RS credit; cdb_r broadcast; dis_vld_r/dis_r to RS.
// Option: TOMASULO_DISPATCH_CDB_BYPASS_EN enables same-cycle CDB-to-source bypass;
//   without it an instruction whose source matches the live broadcast waits one cycle.
module tomasulo_dispatch
  import tomasulo_pkg::*;
#(
  parameter int NREG = 8,
  parameter int NTAG = 8,
  parameter int RS_N = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      ins_vld,
  input  inst_t     ins,
  output logic      ins_accept,
  input  logic      rob_full,
  input  logic      rs_iss_vld_r,
  input  cdb_t      cdb_r,
  output logic      dis_vld_r,
  output dispatch_t dis_r
);

  localparam int CRED_W = $clog2(RS_N + 1);

  regstat_t          rf [NREG];
  logic [CRED_W-1:0] credits;
  robid_t            robid;
  logic              tag_avail;
  tag_t              new_tag;
  logic              bypass_stall;
  logic [1:0]        cdb_hit;
  oprand_t [1:0]     opr;

  tomasulo_tag_alloc #(.NTAG(NTAG)) u_tag_alloc (
    .clk       (clk),
    .rst       (rst),
    .alloc     (ins_accept),
    .rel       (cdb_r.vld),
    .rel_tag   (cdb_r.tag),
    .avail     (tag_avail),
    .alloc_tag (new_tag)
  );

  // Operands read the mapping as it stands before this instruction's own
  // rename, so src == dst naturally returns the previous value/tag.
  always_comb begin
    bypass_stall = 1'b0;
    cdb_hit      = '0;
    opr          = '0;
    for (int o = 0; o < 2; o++) begin
      cdb_hit[o] = rf[ins.src[o]].busy & cdb_r.vld & (rf[ins.src[o]].tag == cdb_r.tag);
      if (!rf[ins.src[o]].busy) begin
        opr[o] = mk_val(rf[ins.src[o]].data);
`ifdef TOMASULO_DISPATCH_CDB_BYPASS_EN
      end else if (cdb_hit[o]) begin
        opr[o] = mk_val(cdb_r.wdata);
`endif
      end else begin
        opr[o] = mk_tag(rf[ins.src[o]].tag);
      end
    end
`ifndef TOMASULO_DISPATCH_CDB_BYPASS_EN
    // The RS would miss this broadcast; wait until the writeback lands.
    bypass_stall = |cdb_hit;
`endif
  end

  assign ins_accept = ins_vld & ~rob_full & (credits != '0) & tag_avail & ~bypass_stall;

  // CDB writeback first, then rename: a same-cycle rename of the same
  // register overrides busy/tag while the data field still takes wdata.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) rf[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (cdb_r.vld && rf[r].busy && (rf[r].tag == cdb_r.tag)) begin
          rf[r].data <= cdb_r.wdata;
          rf[r].busy <= 1'b0;
        end
        if (ins_accept && (ins.dst == reg_t'(r))) begin
          rf[r].busy <= 1'b1;
          rf[r].tag  <= new_tag;
        end
      end
    end
  end

  // Credits mirror free RS slots, covering the RS full flag's pipeline lag.
  always_ff @(posedge clk) begin
    if (rst) begin
      credits <= CRED_W'(RS_N);
    end else begin
      case ({ins_accept, rs_iss_vld_r})
        2'b10:   credits <= credits - CRED_W'(1);
        2'b01: begin
          assert (credits != CRED_W'(RS_N));
          if (credits != CRED_W'(RS_N)) credits <= credits + CRED_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      robid     <= '0;
      dis_vld_r <= 1'b0;
    end else begin
      dis_vld_r <= ins_accept;
      if (ins_accept) robid <= robid + robid_t'(1);
    end
  end

  // Payload register is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!rst && ins_accept) begin
      dis_r.opcode <= ins.opcode;
      dis_r.robid  <= robid;
      dis_r.tag    <= new_tag;
      dis_r.oprand <= opr;
      dis_r.imm    <= ins.imm;
    end
  end

endmodule

// File: tb/tb_tomasulo_dispatch.sv
module tb_tomasulo_dispatch;
  import tomasulo_pkg::*;

  logic      clk = 1'b0;
  logic      rst;
  logic      ins_vld;
  inst_t     ins;
  logic      ins_accept;
  logic      rob_full;
  logic      rs_iss_vld_r;
  cdb_t      cdb_r;
  logic      dis_vld_r;
  dispatch_t dis_r;

  int checks = 0;
  int errors = 0;

`ifdef TOMASULO_DISPATCH_CDB_BYPASS_EN
  localparam logic [2:0] T6_EXP = 3'd3;
`else
  localparam logic [2:0] T6_EXP = 3'd2;
`endif

  tomasulo_dispatch #(.NREG(8), .NTAG(8), .RS_N(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .ins_vld      (ins_vld),
    .ins          (ins),
    .ins_accept   (ins_accept),
    .rob_full     (rob_full),
    .rs_iss_vld_r (rs_iss_vld_r),
    .cdb_r        (cdb_r),
    .dis_vld_r    (dis_vld_r),
    .dis_r        (dis_r)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ins(input opcode_t op, input int dst, input int s0, input int s1,
                         input logic [15:0] imm);
    ins.opcode = op;
    ins.dst    = reg_t'(dst);
    ins.src[0] = reg_t'(s0);
    ins.src[1] = reg_t'(s1);
    ins.imm    = imm;
  endtask

  task automatic set_cdb(input int tag, input logic [31:0] w);
    cdb_r.vld   = 1'b1;
    cdb_r.tag   = tag_t'(tag);
    cdb_r.wdata = w;
  endtask

  task automatic chk_dis(input string name, input int tag, input int robid);
    chk({name, "_vld"},   dis_vld_r,  1);
    chk({name, "_tag"},   dis_r.tag,  tag);
    chk({name, "_robid"}, dis_r.robid, robid);
  endtask

  initial begin
    rst = 1'b1; ins_vld = 1'b0; ins = '0; rob_full = 1'b0; rs_iss_vld_r = 1'b0; cdb_r = '0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_dis_vld", dis_vld_r, 0);
    chk("reset_accept", ins_accept, 0);

    // First instruction: rob_full blocks, then accepted with idle sources.
    set_ins(OP_ADD, 1, 2, 3, 16'h0011); ins_vld = 1'b1; rob_full = 1'b1; #1;
    chk("rob_full_stall", ins_accept, 0);
    rob_full = 1'b0; #1;
    chk("t1_accept", ins_accept, 1);
    tick();
    chk_dis("t1", 0, 0);
    chk("t1_op", dis_r.opcode, OP_ADD);
    chk("t1_imm", dis_r.imm, 16'h0011);
    chk("t1_o0_busy", dis_r.oprand[0].busy, 0);
    chk("t1_o0_w", dis_r.oprand[0].u.w, 0);
    chk("t1_o1_busy", dis_r.oprand[1].busy, 0);
    chk("t1_r1_busy", dut.rf[1].busy, 1);
    chk("t1_r1_tag", dut.rf[1].tag, 0);

    // Dependent instruction: both sources wait on tag 0.
    set_ins(OP_SUB, 4, 1, 1, 16'h0022); #1;
    chk("t2_accept", ins_accept, 1);
    tick();
    chk_dis("t2", 1, 1);
    chk("t2_o0_busy", dis_r.oprand[0].busy, 1);
    chk("t2_o0_tag", dis_r.oprand[0].u.t.tag, 0);
    chk("t2_o1_busy", dis_r.oprand[1].busy, 1);
    chk("t2_o1_tag", dis_r.oprand[1].u.t.tag, 0);

    // CDB retires tag 0 into reg1.
    ins_vld = 1'b0; set_cdb(0, 32'hDEAD);
    tick();
    cdb_r = '0;
    chk("cdb_dis_vld", dis_vld_r, 0);
    chk("cdb_r1_busy", dut.rf[1].busy, 0);
    chk("cdb_r1_data", dut.rf[1].data, 32'hDEAD);

    // Tag 0 is reusable; reg1 now holds data, reg4 still waits on tag 1.
    set_ins(OP_AND, 5, 1, 4, 16'h0033); ins_vld = 1'b1; #1;
    chk("t3_accept", ins_accept, 1);
    tick();
    ins_vld = 1'b0;
    chk_dis("t3", 0, 2);
    chk("t3_o0_busy", dis_r.oprand[0].busy, 0);
    chk("t3_o0_w", dis_r.oprand[0].u.w, 32'hDEAD);
    chk("t3_o1_busy", dis_r.oprand[1].busy, 1);
    chk("t3_o1_tag", dis_r.oprand[1].u.t.tag, 1);

    // Return three credits (back to 4).
    rs_iss_vld_r = 1'b1;
    repeat (3) tick();
    rs_iss_vld_r = 1'b0;

    // Rename reg1 onto tag 2.
    set_ins(OP_OR, 1, 0, 0, 16'h0044); ins_vld = 1'b1; #1;
    tick();
    chk_dis("t4", 2, 3);
    chk("t4_o0_w", dis_r.oprand[0].u.w, 0);

    // Source reg1 busy on tag 2 while tag 2 is broadcast.
    set_ins(OP_XOR, 6, 1, 0, 16'h0055); set_cdb(2, 32'h55); #1;
`ifdef TOMASULO_DISPATCH_CDB_BYPASS_EN
    chk("byp_accept", ins_accept, 1);
    tick();
    cdb_r = '0; ins_vld = 1'b0;
`else
    chk("byp_stall", ins_accept, 0);
    tick();
    cdb_r = '0; #1;
    chk("byp_stall_dis_vld", dis_vld_r, 0);
    chk("byp_retry_accept", ins_accept, 1);
    tick();
    ins_vld = 1'b0;
`endif
    chk_dis("byp", int'(T6_EXP), 4);
    chk("byp_o0_busy", dis_r.oprand[0].busy, 0);
    chk("byp_o0_w", dis_r.oprand[0].u.w, 32'h55);

    // Retire reg6's tag and restore credits to 4; free tags are now 2..7.
    set_cdb(int'(T6_EXP), 32'h66); rs_iss_vld_r = 1'b1;
    tick();
    cdb_r = '0;
    tick();
    rs_iss_vld_r = 1'b0;

    // Five back-to-back: four accepted, fifth blocked on credits.
    set_ins(OP_ADD, 2, 0, 0, 16'h0001); ins_vld = 1'b1; #1;
    tick();
    chk_dis("cr1", 2, 5);
    set_ins(OP_ADD, 7, 0, 0, 16'h0002);
    tick();
    chk_dis("cr2", 3, 6);
    tick();
    chk_dis("cr3", 4, 7);
    tick();
    chk_dis("cr4", 5, 8);
    chk("cr5_stall", ins_accept, 0);
    tick();
    chk("cr5_stall_dis_vld", dis_vld_r, 0);
    rs_iss_vld_r = 1'b1; #1;
    chk("cr5_same_cycle", ins_accept, 0);
    tick();
    rs_iss_vld_r = 1'b0; #1;
    chk("cr5_accept", ins_accept, 1);
    tick();
    chk_dis("cr5", 6, 9);

    // Consume the last tag.
    ins_vld = 1'b0; rs_iss_vld_r = 1'b1;
    tick();
    rs_iss_vld_r = 1'b0; ins_vld = 1'b1; #1;
    tick();
    chk_dis("last_tag", 7, 10);
    ins_vld = 1'b0; rs_iss_vld_r = 1'b1;
    repeat (2) tick();
    rs_iss_vld_r = 1'b0;

    // Tag pool empty with credits available.
    set_ins(OP_SUB, 2, 0, 0, 16'h0009); ins_vld = 1'b1; #1;
    chk("tag_empty", ins_accept, 0);
    tick();
    chk("tag_empty_dis_vld", dis_vld_r, 0);
    set_cdb(3, 32'h33); #1;
    chk("release_same_cycle", ins_accept, 0);
    tick();
    // Tag 3 now free; rename reg2 while its old tag 2 is broadcast.
    set_cdb(2, 32'h22); #1;
    chk("release_next_accept", ins_accept, 1);
    tick();
    cdb_r = '0; ins_vld = 1'b0;
    chk_dis("rename_win", 3, 11);
    chk("rename_r2_busy", dut.rf[2].busy, 1);
    chk("rename_r2_tag", dut.rf[2].tag, 3);
    chk("rename_r2_data", dut.rf[2].data, 32'h22);

    // Reset mid-operation with an instruction pending.
    rst = 1'b1;
    set_ins(OP_ADD, 3, 1, 2, 16'h0077); ins_vld = 1'b1;
    tick();
    rst = 1'b0; #1;
    chk("rst_dis_vld", dis_vld_r, 0);
    chk("rst_accept", ins_accept, 1);
    tick();
    ins_vld = 1'b0;
    chk_dis("post_rst", 0, 0);
    chk("post_rst_o0_busy", dis_r.oprand[0].busy, 0);
    chk("post_rst_o0_w", dis_r.oprand[0].u.w, 0);
    chk("post_rst_o1_busy", dis_r.oprand[1].busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
